// File: rtl/grf_pkg.sv
// grf_pkg: shared GRF write-back op codes, entry layout and op resolution
package grf_pkg;
  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;
  localparam logic [GRF_ADDR_W-1:0] LINK_REG = 5'd31;
  typedef enum logic [1:0] {GRFOP_FULL, GRFOP_LUI, GRFOP_LINK, GRFOP_SET} grfop_e;
  typedef struct packed {
    logic [GRF_ADDR_W-1:0] addr;
    logic [GRF_DATA_W-1:0] data;
    logic [GRF_DATA_W-1:0] pc;
  } grf_entry_t;
  function automatic grf_entry_t resolve(grfop_e op, logic [GRF_ADDR_W-1:0] addr,
                                         logic [GRF_DATA_W-1:0] data, logic [GRF_DATA_W-1:0] pc);
    grf_entry_t e;
    e.pc = pc;
    e.addr = op == GRFOP_LINK ? LINK_REG : addr;
    e.data = op == GRFOP_LUI ? data << 16 :
             op == GRFOP_LINK ? pc + GRF_DATA_W'(4) :
             op == GRFOP_SET ? GRF_DATA_W'(1) : data;
    return e;
  endfunction
endpackage

// File: rtl/grf_wb_fifo.sv
// grf_wb_fifo: circular write buffer, two enqueue ports, one dequeue port, per-entry valid/addr export
module grf_wb_fifo import grf_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en0,
  input  grf_entry_t                           in0,
  input  logic                                 en1,
  input  grf_entry_t                           in1,
  input  logic                                 deq,
  output grf_entry_t                           head,
  output logic [CW-1:0]                        count,
  output logic [DEPTH-1:0]                     valid,
  output logic [DEPTH-1:0][GRF_ADDR_W-1:0]     addrs
);
  logic [PW-1:0] wp, rp;
  grf_entry_t mem [DEPTH];
  wire [PW-1:0] wp1 = wp + PW'(en0);
  assign head = mem[rp];
  for (genvar i = 0; i < DEPTH; i++) begin : g_addr
    assign addrs[i] = mem[i].addr;
  end
  // storage; port 1 lands behind port 0 when both write
  always_ff @(posedge clk) begin
    if (en0) mem[wp] <= in0;
    if (en1) mem[wp1] <= in1;
  end
  // pointers, occupancy and valid bits; a write into the slot being read wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (deq) begin
        rp <= rp + PW'(1);
        valid[rp] <= 1'b0;
      end
      if (en0) valid[wp] <= 1'b1;
      if (en1) valid[wp1] <= 1'b1;
      wp <= wp + PW'(en0) + PW'(en1);
      count <= count + CW'(en0) + CW'(en1) - CW'(deq);
    end
  end
endmodule

// File: rtl/grf_writeback.sv
// grf_writeback: resolves pipeline and mult/div register writes, buffers them in order, drains one per cycle to the GRF
// Define GRF_WB_TRACE_EN to print a trace line for every GRF write.
module grf_writeback import grf_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_valid,
  output logic              pipe_ready,
  input  logic [1:0]        pipe_op,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic [DATA_W-1:0] pipe_pc,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [1:0]        md_op,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0] md_data,
  input  logic [DATA_W-1:0] md_pc,
  output logic              grf_we,
  output logic [ADDR_W-1:0] grf_addr,
  output logic [DATA_W-1:0] grf_data,
  output logic [DATA_W-1:0] grf_pc,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              pend_hit,
  output logic [CW-1:0]     count
);
  grf_entry_t pe, me, head;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0][GRF_ADDR_W-1:0] addrs;
  logic [CW:0] free;
  logic deq;
  assign deq = count != '0;
  assign free = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(deq);
  assign pipe_ready = free >= (CW+1)'(1);
  assign md_ready = free >= (CW+1)'(2) || (free >= (CW+1)'(1) && !pipe_valid);
  assign pe = resolve(grfop_e'(pipe_op), pipe_addr, pipe_data, pipe_pc);
  assign me = resolve(grfop_e'(md_op), md_addr, md_data, md_pc);
  grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset),
    .en0(pipe_valid && pipe_ready && pe.addr != '0), .in0(pe),
    .en1(md_valid && md_ready && me.addr != '0), .in1(me),
    .deq(deq), .head(head), .count(count), .valid(valid), .addrs(addrs)
  );
  // output register: load the FIFO head whenever one exists, else hold the last write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we <= 1'b0;
      grf_addr <= '0;
      grf_data <= '0;
      grf_pc <= '0;
    end else begin
      grf_we <= deq;
      if (deq) begin
        grf_addr <= head.addr;
        grf_data <= head.data;
        grf_pc <= head.pc;
      end
    end
  end
  // scoreboard: any buffered or outgoing write to a nonzero queried register
  always_comb begin
    pend_hit = grf_we && grf_addr == pend_addr;
    for (int i = 0; i < DEPTH; i++) pend_hit = pend_hit || (valid[i] && addrs[i] == pend_addr);
    pend_hit = pend_hit && pend_addr != '0;
  end
`ifdef GRF_WB_TRACE_EN
  // write trace
  always @(posedge clk) if (grf_we) $display("@%h: $%d <= %h", grf_pc, grf_addr, grf_data);
`endif
endmodule

// File: tb/tb_grf_writeback.sv
// tb_grf_writeback: scoreboard bench for grf_writeback
module tb_grf_writeback;
  localparam int DEPTH = 4;
  typedef struct {logic [4:0] a; logic [31:0] d; logic [31:0] p;} exp_t;
  logic clk = 0, reset = 0;
  logic pipe_valid = 0, md_valid = 0, pipe_ready, md_ready, grf_we, pend_hit;
  logic [1:0] pipe_op = 0, md_op = 0;
  logic [4:0] pipe_addr = 0, md_addr = 0, grf_addr, pend_addr = 0;
  logic [31:0] pipe_data = 0, pipe_pc = 0, md_data = 0, md_pc = 0, grf_data, grf_pc;
  logic [2:0] count;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic md_acc;
  always #5 clk = ~clk;
  grf_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_op(pipe_op), .pipe_addr(pipe_addr),
    .pipe_data(pipe_data), .pipe_pc(pipe_pc),
    .md_valid(md_valid), .md_ready(md_ready), .md_op(md_op), .md_addr(md_addr),
    .md_data(md_data), .md_pc(md_pc),
    .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data), .grf_pc(grf_pc),
    .pend_addr(pend_addr), .pend_hit(pend_hit), .count(count)
  );
  function automatic exp_t model(logic [1:0] op, logic [4:0] a, logic [31:0] d, logic [31:0] p);
    exp_t e;
    e.a = a; e.d = d; e.p = p;
    case (op)
      2'd1: e.d = {d[15:0], 16'h0};
      2'd2: begin e.a = 5'd31; e.d = p + 32'd4; end
      2'd3: e.d = 32'd1;
      default: ;
    endcase
    return e;
  endfunction
  task automatic set_pipe(input logic v, input logic [1:0] op, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    pipe_valid = v; pipe_op = op; pipe_addr = a; pipe_data = d; pipe_pc = p;
  endtask
  task automatic set_md(input logic v, input logic [1:0] op, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    md_valid = v; md_op = op; md_addr = a; md_data = d; md_pc = p;
  endtask
  task automatic step();
    int fr;
    logic exp_mr;
    exp_t e;
    #1;
    fr = DEPTH - sb.size() + (sb.size() != 0 ? 1 : 0);
    exp_mr = fr >= 2 || (fr >= 1 && !pipe_valid);
    checks++;
    if (pipe_ready !== (fr >= 1)) begin errors++; $display("FAIL pipe_ready got %b want %b", pipe_ready, fr >= 1); end
    checks++;
    if (md_ready !== exp_mr) begin errors++; $display("FAIL md_ready got %b want %b (free %0d pipe_valid %b)", md_ready, exp_mr, fr, pipe_valid); end
    if (pipe_valid && exp_mr | 1'b1 && fr >= 1) begin
      e = model(pipe_op, pipe_addr, pipe_data, pipe_pc);
      if (e.a != 0) sb.push_back(e);
    end
    md_acc = md_valid && exp_mr;
    if (md_acc) begin
      e = model(md_op, md_addr, md_data, md_pc);
      if (e.a != 0) sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (grf_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL unexpected_write got $%0d=%h want none", grf_addr, grf_data);
      end else begin
        e = sb.pop_front();
        if (grf_addr !== e.a || grf_data !== e.d || grf_pc !== e.p) begin
          errors++;
          $display("FAIL write got $%0d=%h pc %h want $%0d=%h pc %h", grf_addr, grf_data, grf_pc, e.a, e.d, e.p);
        end
      end
    end
    checks++;
    if (count !== 3'(sb.size())) begin errors++; $display("FAIL count got %0d want %0d", count, sb.size()); end
  endtask
  task automatic drain();
    set_pipe(0, 0, 0, 0, 0); set_md(0, 0, 0, 0, 0);
    for (int i = 0; i < 12 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL drain got %0d left want 0", sb.size()); end
    step();
  endtask
  task automatic test_reset();
    pend_addr = 5'd8;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({count, grf_we, grf_addr, grf_data, grf_pc, pend_hit, pipe_ready, md_ready} !== {3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset got cnt %0d we %b a %0d d %h pc %h hit %b rdy %b%b want 0 0 0 0 0 0 11", count, grf_we, grf_addr, grf_data, grf_pc, pend_hit, pipe_ready, md_ready);
    end
    reset = 1;
  endtask
  task automatic test_full();
    set_pipe(1, 0, 5'd8, 32'h12345678, 32'h3000);
    step();
    checks++;
    if (grf_we !== 1'b0) begin errors++; $display("FAIL full_early got %b want 0", grf_we); end
    set_pipe(0, 0, 0, 0, 0);
    step();
    checks++;
    if (grf_we !== 1'b1 || grf_addr !== 5'd8 || grf_data !== 32'h12345678) begin
      errors++; $display("FAIL full_write got %b $%0d=%h want 1 $8=12345678", grf_we, grf_addr, grf_data);
    end
    checks++;
    if (pend_hit !== 1'b1) begin errors++; $display("FAIL pend_set got %b want 1", pend_hit); end
    step();
    checks++;
    if (pend_hit !== 1'b0 || grf_we !== 1'b0) begin errors++; $display("FAIL pend_clear got hit %b we %b want 0 0", pend_hit, grf_we); end
  endtask
  task automatic test_link_lui();
    set_pipe(1, 2'd2, 5'd5, 32'hDEAD, 32'h3010);
    set_md(1, 2'd1, 5'd9, 32'h0000ABCD, 32'h3014);
    step();
    set_pipe(0, 0, 0, 0, 0); set_md(0, 0, 0, 0, 0);
    step();
    checks++;
    if (grf_addr !== 5'd31 || grf_data !== 32'h00003014) begin errors++; $display("FAIL link got $%0d=%h want $31=00003014", grf_addr, grf_data); end
    step();
    checks++;
    if (grf_addr !== 5'd9 || grf_data !== 32'hABCD0000) begin errors++; $display("FAIL lui got $%0d=%h want $9=abcd0000", grf_addr, grf_data); end
    drain();
  endtask
  task automatic test_addr0();
    for (int k = 0; k < 2; k++) begin
      set_pipe(1, k == 0 ? 2'd3 : 2'd0, 5'd0, 32'h55, 32'h4000);
      step();
      set_pipe(0, 0, 0, 0, 0);
      step();
      checks++;
      if (grf_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL addr0_%0d got we %b cnt %0d want 0 0", k, grf_we, count); end
    end
  endtask
  task automatic test_back_to_back();
    int maxc = 0;
    for (int i = 0; i < 20; i++) begin
      set_pipe(1, 2'($urandom_range(0, 3)), 5'($urandom_range(1, 30)), $urandom, 32'h5000 + 32'(i * 8));
      if (i == 0 || md_acc) set_md(1, 2'($urandom_range(0, 3)), 5'($urandom_range(1, 30)), $urandom, 32'h6000 + 32'(i * 8));
      step();
      if (int'(count) > maxc) maxc = int'(count);
      if (i > 0) begin
        checks++;
        if (grf_we !== 1'b1) begin errors++; $display("FAIL b2b_we cycle %0d got %b want 1", i, grf_we); end
      end
    end
    checks++;
    if (maxc != DEPTH) begin errors++; $display("FAIL b2b_sat got %0d want %0d", maxc, DEPTH); end
    drain();
  endtask
  task automatic test_reset_mid();
    set_pipe(1, 0, 5'd10, 32'hA, 32'h7000);
    set_md(1, 0, 5'd11, 32'hB, 32'h7004);
    step();
    step();
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL mid_fill got %0d want 3", count); end
    set_pipe(0, 0, 0, 0, 0); set_md(0, 0, 0, 0, 0);
    reset = 0;
    #1;
    checks++;
    if (count !== 3'd0 || grf_we !== 1'b0 || grf_addr !== 5'd0) begin
      errors++; $display("FAIL mid_reset got cnt %0d we %b a %0d want 0 0 0", count, grf_we, grf_addr);
    end
    sb.delete();
    @(posedge clk);
    #1 reset = 1;
    repeat (3) step();
  endtask
  initial begin
    test_reset();
    test_full();
    test_link_lui();
    test_addr0();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/grf_writeback.md
# grf_writeback

Write-back initiator for the general register file: collects register-write requests from the in-order pipeline and from the multi-cycle multiply/divide unit, resolves the write operation (full, load-upper, link, set), buffers them in order in a small FIFO, and drains exactly one write per cycle onto the GRF write port. A scoreboard output flags registers with writes still in flight, so the hazard unit can stall readers.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- DATA_W, 32, data and PC width
- ADDR_W, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pipe_valid  in  1  pipeline write request
- pipe_ready  out  1  pipeline request accepted this cycle when high
- pipe_op  in  2  GRFOP: 0 FULL, 1 LUI, 2 LINK, 3 SET
- pipe_addr  in  ADDR_W  destination register
- pipe_data  in  DATA_W  raw result
- pipe_pc  in  DATA_W  PC of the producing instruction
- md_valid, md_ready, md_op, md_addr, md_data, md_pc: same meanings for the mult/div source
- grf_we  out  1  GRF write enable
- grf_addr  out  ADDR_W  GRF write address
- grf_data  out  DATA_W  GRF write data, already resolved
- grf_pc  out  DATA_W  PC of the write, for trace
- pend_addr  in  ADDR_W  scoreboard query register
- pend_hit  out  1  pend_addr has a write pending in the FIFO or the output register
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Op resolution at enqueue:
  - FULL: data unchanged.
  - LUI: data << 16, low 16 bits zero.
  - LINK: addr forced to 31, data = pc + 4 (mod 2^DATA_W).
  - SET: data = 1.
- A write whose resolved addr is 0 is accepted and discarded. It is never enqueued.
- Free slots: free = DEPTH − count + (count≠0). A non-empty FIFO always dequeues one entry this cycle.
- pipe_ready = free ≥ 1. md_ready = free ≥ 2, or (free ≥ 1 and !pipe_valid). Pipeline has priority.
- When both sources are accepted in the same cycle, the pipe entry is enqueued ahead of the md entry. FIFO order equals acceptance order.
- Drain: if count≠0, the head is loaded into the output register with grf_we=1. Otherwise grf_we=0 next cycle, and grf_addr/grf_data/grf_pc hold their last values.
- pend_hit is combinational from state only: pend_addr≠0 and it matches any valid FIFO entry or (grf_we and grf_addr). Incoming same-cycle requests are not included.

## Timing
- Reset (async assert, sync-released flops): count=0, grf_we=0, grf_addr=0, grf_data=0, grf_pc=0, pend_hit=0, pipe_ready=1, md_ready=1. Reset mid-operation discards all pending entries.
- Latency from an accepting edge N to grf_we high is 1 cycle when count=0 at N, so the GRF commits at edge N+2. Each older entry adds one cycle.
- Throughput: one GRF write per cycle, sustained.
- Full FIFO with simultaneous dequeue: one slot frees, so pipe_ready=1 and md_ready=0 while pipe_valid is high.
- Requests with valid high and ready low must be held stable by the source until accepted.

## Configuration
- GRF_WB_TRACE_EN defined: at every clock edge where grf_we=1, print "@%h: $%d <= %h" with grf_pc, grf_addr, grf_data.
- GRF_WB_TRACE_EN undefined: no display statements are compiled, and behaviour is otherwise identical.

## Structure
- grf_pkg holds:
  - the GRFOP encodings (FULL, LUI, LINK, SET)
  - the LINK register index 31
  - the DATA_W/ADDR_W defaults
  - the FIFO entry struct {addr, data, pc}
- Sub-module grf_wb_fifo: DEPTH-entry circular buffer with two enqueue ports and one dequeue port. It uses wrap-around pointers and exports per-entry valid/addr for the scoreboard.

## Test plan
- Reset, then pipe FULL addr 8 data 0x12345678 pc 0x3000 → grf_we one cycle after accept with $8 = 0x12345678. pend_hit for query 8 during that cycle, cleared the cycle after.
- Pipe LINK pc 0x3010, plus md LUI addr 9 data 0xABCD in the same cycle → writes in order: $31 = 0x00003014, then $9 = 0xABCD0000.
- Pipe SET addr 0 → accepted, no grf_we, count stays 0. Pipe FULL addr 0 behaves the same.
- Both sources valid every cycle for 20 cycles → count saturates at DEPTH. Exactly one write per cycle. md_ready low whenever pipe_valid and free=1. No loss or reordering.
- Assert reset with count=3 → count=0 and grf_we=0 immediately. No stale writes appear after release.
- Build without GRF_WB_TRACE_EN → no output in the log. Build with it → one line per write, matching the expected values.
